// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin priority pick for mux_rr_arbiter.
// The pick works on a fixed maximum width so one function serves every instance size.
package mux_arb_pkg;

  localparam int unsigned MAX_SEL_LINES = 6;
  localparam int unsigned MAX_N         = 2 ** MAX_SEL_LINES;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic                     found;
    logic [MAX_SEL_LINES-1:0] idx;
  } pick_t;

  function automatic int unsigned num_req(input int unsigned sel_lines);
    return 32'(1) << sel_lines;
  endfunction

  // Circular search starting just after `last`; n must be a power of two <= MAX_N.
  function automatic pick_t rr_pick(
    input logic [MAX_N-1:0]         req,
    input logic [MAX_SEL_LINES-1:0] last,
    input logic                     exclude_en,
    input logic [MAX_SEL_LINES-1:0] exclude_idx,
    input int unsigned              n
  );
    pick_t                    p;
    int unsigned              cand;
    logic [MAX_SEL_LINES-1:0] c;
    p = '0;
    for (int unsigned off = 1; off <= MAX_N; off++) begin
      cand = (32'(last) + off) & (n - 32'(1));
      c    = MAX_SEL_LINES'(cand);
      if (!p.found && (off <= n) && req[c] && !(exclude_en && (c == exclude_idx))) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux.sv
// Shared 2**SELECT_LINES:1 single-bit multiplexer.
// ARCHITECTURE picks between an indexed read and a decoded AND-OR form; both are equivalent.
module mux #(
  parameter int unsigned SELECT_LINES = 2,
  parameter string       ARCHITECTURE = "BEHAVIORAL"
) (
  input  logic [(2**SELECT_LINES)-1:0] in,
  input  logic [SELECT_LINES-1:0]      select,
  output logic                         out
);

  localparam int unsigned N = 2 ** SELECT_LINES;

  generate
    if (ARCHITECTURE == "AND_OR") begin : g_and_or
      logic [N-1:0] dec;
      assign dec = N'(1) << select;
      assign out = |(in & dec);
    end else begin : g_behavioral
      assign out = in[select];
    end
  endgenerate

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared mux on behalf of N requesters,
// with a hold limit that forces rotation when the owner hogs the resource.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned SELECT_LINES = 2,
  parameter string       ARCHITECTURE = "BEHAVIORAL",
  parameter int unsigned MAX_HOLD     = 8,
  parameter int unsigned HOLD_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [(2**SELECT_LINES)-1:0] req,
  input  logic [(2**SELECT_LINES)-1:0] in,
  output logic [(2**SELECT_LINES)-1:0] grant,
  output logic                         grant_valid,
  output logic [SELECT_LINES-1:0]      select,
  output logic                         out,
  output logic                         preempt
);

  localparam int unsigned N = num_req(SELECT_LINES);

  state_e                  state_q, state_d;
  logic [N-1:0]            grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [SELECT_LINES-1:0] select_q, select_d;
  logic [SELECT_LINES-1:0] last_q, last_d;
  logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
  logic                    preempt_q, preempt_d;

  logic [MAX_N-1:0]        req_ext;
  logic                    others_pending;
  logic                    hold_at_limit;
  logic [HOLD_WIDTH-1:0]   hold_inc;
  pick_t                   pick_idle;
  pick_t                   pick_rot;

  // Priority candidates: from last owner when idle, from current owner (excluded) when owned.
  always_comb begin
    req_ext        = MAX_N'(req);
    others_pending = |(req & ~grant_q);
    hold_at_limit  = (MAX_HOLD != 0) && (32'(hold_q) >= MAX_HOLD);
    hold_inc       = (hold_q == '1) ? hold_q : hold_q + HOLD_WIDTH'(1);
    pick_idle      = rr_pick(req_ext, MAX_SEL_LINES'(last_q), 1'b0, '0, N);
    pick_rot       = rr_pick(req_ext, MAX_SEL_LINES'(select_q), 1'b1,
                             MAX_SEL_LINES'(select_q), N);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    select_d      = select_q;
    last_d        = last_q;
    hold_d        = hold_q;
    preempt_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d       = GRANT;
          grant_d       = N'(1) << pick_idle.idx;
          grant_valid_d = 1'b1;
          select_d      = SELECT_LINES'(pick_idle.idx);
          last_d        = SELECT_LINES'(pick_idle.idx);
          hold_d        = HOLD_WIDTH'(1);
        end
      end

      GRANT: begin
        if (req[select_q]) begin
          if (!others_pending) begin
            if (32'(hold_q) < MAX_HOLD) begin
              hold_d = hold_inc;
            end
          end else if (!hold_at_limit) begin
            hold_d = hold_inc;
          end else if (pick_rot.found) begin
            grant_d   = N'(1) << pick_rot.idx;
            select_d  = SELECT_LINES'(pick_rot.idx);
            last_d    = SELECT_LINES'(pick_rot.idx);
            hold_d    = HOLD_WIDTH'(1);
            preempt_d = 1'b1;
          end
        end else if (pick_rot.found) begin
          // Owner released with others waiting: hand off on the same edge.
          grant_d  = N'(1) << pick_rot.idx;
          select_d = SELECT_LINES'(pick_rot.idx);
          last_d   = SELECT_LINES'(pick_rot.idx);
          hold_d   = HOLD_WIDTH'(1);
        end else begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      select_q      <= '0;
      last_q        <= '1;
      hold_q        <= '0;
      preempt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      select_q      <= select_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      preempt_q     <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign select      = select_q;
  assign preempt     = preempt_q;

  mux #(
    .SELECT_LINES (SELECT_LINES),
    .ARCHITECTURE (ARCHITECTURE)
  ) u_mux (
    .in     (in),
    .select (select_q),
    .out    (out)
  );

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one `mux` instance between 2**SELECT_LINES single-bit requesters.
- Each requester raises `req` and owns the mux while it holds `req`. A hold limit forces rotation when others wait.
- Drives the mux `select` from the registered grant owner and exposes the muxed bit plus the grant state.
- Sits between requester logic and the shared mux datapath, replacing hand-driven `select` in higher blocks.

Parameters:
- SELECT_LINES, 2: mux select width; N = 2**SELECT_LINES requesters.
- ARCHITECTURE, "BEHAVIORAL": passed unchanged to the `mux` instance.
- MAX_HOLD, 8: maximum consecutive grant cycles while another requester waits. 0 disables preemption.
- HOLD_WIDTH, 4: width of hold counter. Must satisfy 2**HOLD_WIDTH > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- req  in  N  per-requester request level; held high for the whole transfer.
- in  in  N  per-requester data bit into the shared mux.
- grant  out  N  one-hot registered grant, all-zero when idle.
- grant_valid  out  1  OR of grant, registered.
- select  out  SELECT_LINES  registered index of current or last owner; drives mux select.
- out  out  1  mux output, in[select], combinational from `in`/`select`.
- preempt  out  1  one-cycle pulse on a forced rotation.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, select=0, preempt=0.
  - last_owner=N-1, so requester 0 has highest priority after reset; hold_cnt=0; state=IDLE.
- Priority: circular search starting at last_owner+1 mod N. The first asserted req wins.
- IDLE:
  - If any req is high at edge t, the winner is granted. grant, select and grant_valid update at edge t (one-cycle latency from req seen to grant).
  - Transition to GRANT; hold_cnt=1.
- GRANT (owner k):
  - req[k]=1 and no other req: keep grant; hold_cnt saturates at MAX_HOLD.
  - req[k]=1, another req pending, hold_cnt<MAX_HOLD or MAX_HOLD=0: keep grant; hold_cnt++.
  - req[k]=1, another req pending, hold_cnt>=MAX_HOLD (MAX_HOLD>0): preempt.
    - Grant the next winner (search from k+1), excluding k.
    - preempt=1 for one cycle; hold_cnt=1; last_owner=new owner.
  - req[k]=0 with others pending: direct handoff at the same edge, no bubble. Search from k+1; hold_cnt=1; preempt stays 0.
  - req[k]=0 with none pending: grant=0, grant_valid=0, go to IDLE. select holds k.
  - last_owner updates on every new grant.
- A preempted requester still holding req competes normally in later rounds. It is last in priority immediately after preemption.
- Simultaneous requests: exactly one grant, never more than one bit set in grant.
- Requests that appear and vanish within one cycle while the resource is owned are lost; no queuing.
- Reset mid-grant: all outputs return to reset values asynchronously. After rst_n release the first grant takes one edge.
- out is undefined-free: it always reflects in[select], including while idle.

Decomposition:
- Package mux_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Function rr_pick(req, last, exclude_en, exclude_idx) returning {found, index}.
  - Localparam N derivation.
- One sub-module is natural: the existing `mux`, instanced as u_mux with SELECT_LINES and ARCHITECTURE passed through.
- Priority pick stays a package function, not a separate module.

Test Plan (SELECT_LINES=2, MAX_HOLD=3):
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, select=0, preempt never 1.
- req=4'b1010 from cycle 0 -> grant=4'b0010 at edge 1, select=1.
  - Then drop req[1] -> grant=4'b1000 at next edge, select=3, no idle cycle.
- req=4'b0001 held, req[2] raised at cycle 1 -> grant stays 4'b0001 until hold_cnt=3.
  - Next edge: grant=4'b0100, preempt=1 for exactly one cycle.
- All req=4'b1111 held continuously -> grant sequence 0001,0010,0100,1000,0001 with 3 cycles each and a preempt pulse at every change.
- in=4'b0100 with req[2] granted -> out=1. Switch grant to requester 0 -> out=0 on the cycle select becomes 0.
- rst_n low mid-grant (grant=4'b0100) -> grant=0, select=0 immediately.
  - After release with req=4'b0110: grant=4'b0010 one edge later, since last_owner reset to 3.
